wb_stage: RTL and testbench

Writeback stage of the NPC core, directly upstream of the register file. It accepts one retiring instruction per handshake from the memory stage and holds it in a single-entry register. It selects and formats the result, including load byte/half extraction and sign/zero extension. It then drives the register file's write port, reports commit, and latches a halt on `ebreak`.

---
 rtl/wb_stage_if.sv | 27 ++
 rtl/wb_stage.sv | 173 +++++++++++++++++
 tb/tb_wb_stage.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// Memory-stage -> writeback-stage handshake bundle.
// The memory stage drives the instruction fields and valid; the writeback
// stage answers with ready.
interface wb_stage_if;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [31:0] io_in_pc;
    logic [4:0]  io_in_rd;
    logic        io_in_rf_wen;
    logic [1:0]  io_in_sel;
    logic [31:0] io_in_alu_result;
    logic [31:0] io_in_load_data;
    logic [2:0]  io_in_load_type;
    logic        io_in_ebreak;

    modport master (
        output io_in_valid, io_in_pc, io_in_rd, io_in_rf_wen, io_in_sel,
               io_in_alu_result, io_in_load_data, io_in_load_type, io_in_ebreak,
        input  io_in_ready
    );

    modport slave (
        input  io_in_valid, io_in_pc, io_in_rd, io_in_rf_wen, io_in_sel,
               io_in_alu_result, io_in_load_data, io_in_load_type, io_in_ebreak,
        output io_in_ready
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: single-entry holding register between the memory stage
// and the register file. Results are formatted (load extraction/extension,
// PC+4) when captured, so the write port is driven straight from flops.
// Optional decode-stage forwarding ports are enabled by defining WB_BYPASS_EN.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_EMPTY  | no entry held, ready to accept
// S_FULL   | entry held, retires on any cycle without io_hold
// S_HALTED | ebreak retired; only reset leaves this state
module wb_stage (
    input  logic             clock,
    input  logic             reset,
    wb_stage_if.slave        io_in,
    input  logic             io_hold,
`ifdef WB_BYPASS_EN
    input  logic [4:0]       io_byp_raddr1,
    input  logic [4:0]       io_byp_raddr2,
    output logic             io_byp_hit1,
    output logic             io_byp_hit2,
    output logic [31:0]      io_byp_data1,
    output logic [31:0]      io_byp_data2,
`endif
    output logic [4:0]       io_waddr,
    output logic [31:0]      io_wdata,
    output logic             io_wen,
    output logic             io_commit_valid,
    output logic [31:0]      io_commit_pc,
    output logic [31:0]      io_inst_cnt,
    output logic             io_misalign,
    output logic             io_halt,
    output logic             io_busy_valid,
    output logic [4:0]       io_busy_rd
);
    typedef enum logic [1:0] {S_EMPTY, S_FULL, S_HALTED} state_t;

    state_t      r_state;
    logic [4:0]  r_rd;
    logic        r_rf_wen;
    logic [31:0] r_wdata;
    logic [31:0] r_pc;
    logic        r_ebreak;
    logic        r_mis;
    logic [31:0] r_inst_cnt;
    logic        r_misalign;
    logic        r_halt;

    logic        w_retire;
    logic        w_ready;
    logic        w_accept;
    logic        w_load;
    logic [1:0]  w_lane;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;
    logic        w_ld_mis;
    logic [31:0] w_fmt_data;
    logic        w_fmt_mis;

    assign w_retire = (r_state == S_FULL) & ~io_hold;
    assign w_ready  = (r_state == S_EMPTY) | w_retire;
    assign w_accept = io_in.io_in_valid & w_ready;
    // A retiring ebreak halts the core; anything offered alongside it is dropped.
    assign w_load   = w_accept & ~(w_retire & r_ebreak);

    assign io_in.io_in_ready = w_ready;

    // Result formatting on the incoming instruction, ahead of capture.
    always_comb begin
        w_lane = io_in.io_in_alu_result[1:0];
        w_byte = 8'h00;
        case (w_lane)
            2'd0:    w_byte = io_in.io_in_load_data[7:0];
            2'd1:    w_byte = io_in.io_in_load_data[15:8];
            2'd2:    w_byte = io_in.io_in_load_data[23:16];
            default: w_byte = io_in.io_in_load_data[31:24];
        endcase
        w_half    = w_lane[1] ? io_in.io_in_load_data[31:16] : io_in.io_in_load_data[15:0];
        w_ld_data = io_in.io_in_load_data;
        w_ld_mis  = 1'b0;
        case (io_in.io_in_load_type)
            3'b000: w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b100: w_ld_data = {24'h0, w_byte};
            3'b001: begin
                w_ld_data = {{16{w_half[15]}}, w_half};
                w_ld_mis  = w_lane[0];
            end
            3'b101: begin
                w_ld_data = {16'h0, w_half};
                w_ld_mis  = w_lane[0];
            end
            3'b010: w_ld_mis = (w_lane != 2'd0);
            default: w_ld_data = io_in.io_in_load_data;
        endcase
        w_fmt_mis  = 1'b0;
        case (io_in.io_in_sel)
            2'd1: begin
                w_fmt_data = w_ld_data;
                w_fmt_mis  = w_ld_mis;
            end
            2'd2:    w_fmt_data = io_in.io_in_pc + 32'd4;
            default: w_fmt_data = io_in.io_in_alu_result;
        endcase
    end

    // Entry register: loaded on every accepted handshake, cleared by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd     <= 5'd0;
            r_rf_wen <= 1'b0;
            r_wdata  <= 32'd0;
            r_pc     <= 32'd0;
            r_ebreak <= 1'b0;
            r_mis    <= 1'b0;
        end else if (w_load) begin
            r_rd     <= io_in.io_in_rd;
            r_rf_wen <= io_in.io_in_rf_wen;
            r_wdata  <= w_fmt_data;
            r_pc     <= io_in.io_in_pc;
            r_ebreak <= io_in.io_in_ebreak;
            r_mis    <= w_fmt_mis;
        end
    end

    // Stage FSM with retire counter, sticky misalign flag and halt latch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_EMPTY;
            r_inst_cnt <= 32'd0;
            r_misalign <= 1'b0;
            r_halt     <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_load) r_state <= S_FULL;
                end
                S_FULL: begin
                    if (w_retire) begin
                        r_inst_cnt <= r_inst_cnt + 32'd1;
                        if (r_mis) r_misalign <= 1'b1;
                        if (r_ebreak) begin
                            r_state <= S_HALTED;
                            r_halt  <= 1'b1;
                        end else if (!w_load) begin
                            r_state <= S_EMPTY;
                        end
                    end
                end
                S_HALTED: r_state <= S_HALTED;
                default:  r_state <= S_EMPTY;
            endcase
        end
    end

    assign io_waddr        = r_rd;
    assign io_wdata        = r_wdata;
    assign io_wen          = w_retire & r_rf_wen & (r_rd != 5'd0) & ~r_mis;
    assign io_commit_valid = w_retire;
    assign io_commit_pc    = r_pc;
    assign io_inst_cnt     = r_inst_cnt;
    assign io_misalign     = r_misalign;
    assign io_halt         = r_halt;
    assign io_busy_valid   = (r_state == S_FULL) & r_rf_wen & (r_rd != 5'd0);
    assign io_busy_rd      = r_rd;

`ifdef WB_BYPASS_EN
    // Forward the pending result to decode; misaligned entries never write.
    assign io_byp_hit1  = io_busy_valid & ~r_mis & (io_byp_raddr1 == r_rd);
    assign io_byp_hit2  = io_busy_valid & ~r_mis & (io_byp_raddr2 == r_rd);
    assign io_byp_data1 = io_byp_hit1 ? r_wdata : 32'd0;
    assign io_byp_data2 = io_byp_hit2 ? r_wdata : 32'd0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: formatting, hold, misalign, ebreak halt, reset.
module tb_wb_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic        io_hold;
    logic [4:0]  io_waddr;
    logic [31:0] io_wdata;
    logic        io_wen;
    logic        io_commit_valid;
    logic [31:0] io_commit_pc;
    logic [31:0] io_inst_cnt;
    logic        io_misalign;
    logic        io_halt;
    logic        io_busy_valid;
    logic [4:0]  io_busy_rd;
`ifdef WB_BYPASS_EN
    logic [4:0]  io_byp_raddr1;
    logic [4:0]  io_byp_raddr2;
    logic        io_byp_hit1;
    logic        io_byp_hit2;
    logic [31:0] io_byp_data1;
    logic [31:0] io_byp_data2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    wb_stage_if u_if ();

    wb_stage u_dut (
        .clock           (clock),
        .reset           (reset),
        .io_in           (u_if),
        .io_hold         (io_hold),
`ifdef WB_BYPASS_EN
        .io_byp_raddr1   (io_byp_raddr1),
        .io_byp_raddr2   (io_byp_raddr2),
        .io_byp_hit1     (io_byp_hit1),
        .io_byp_hit2     (io_byp_hit2),
        .io_byp_data1    (io_byp_data1),
        .io_byp_data2    (io_byp_data2),
`endif
        .io_waddr        (io_waddr),
        .io_wdata        (io_wdata),
        .io_wen          (io_wen),
        .io_commit_valid (io_commit_valid),
        .io_commit_pc    (io_commit_pc),
        .io_inst_cnt     (io_inst_cnt),
        .io_misalign     (io_misalign),
        .io_halt         (io_halt),
        .io_busy_valid   (io_busy_valid),
        .io_busy_rd      (io_busy_rd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                       input logic wen, input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [2:0] lt, input logic eb);
        u_if.io_in_valid      = v;
        u_if.io_in_pc         = pc;
        u_if.io_in_rd         = rd;
        u_if.io_in_rf_wen     = wen;
        u_if.io_in_sel        = sel;
        u_if.io_in_alu_result = alu;
        u_if.io_in_load_data  = ld;
        u_if.io_in_load_type  = lt;
        u_if.io_in_ebreak     = eb;
    endtask

    task automatic idle();
        put(1'b0, 32'h0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 3'd0, 1'b0);
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        reset   = 1'b1;
        io_hold = 1'b0;
        idle();
`ifdef WB_BYPASS_EN
        io_byp_raddr1 = 5'd0;
        io_byp_raddr2 = 5'd0;
`endif
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_ready", u_if.io_in_ready, 1);
        check("rst_wen", io_wen, 0);
        check("rst_waddr", io_waddr, 0);
        check("rst_wdata", io_wdata, 0);
        check("rst_commit", io_commit_valid, 0);
        check("rst_cpc", io_commit_pc, 0);
        check("rst_cnt", io_inst_cnt, 0);
        check("rst_mis", io_misalign, 0);
        check("rst_halt", io_halt, 0);
        check("rst_busy", io_busy_valid, 0);
        check("rst_busy_rd", io_busy_rd, 0);

        // ALU result
        put(1, 32'h8000_0000, 5'd5, 1, 2'd0, 32'h1234_5678, 32'h0, 3'd0, 0);
        step();
        check("alu_wen", io_wen, 1);
        check("alu_waddr", io_waddr, 5);
        check("alu_wdata", io_wdata, 32'h1234_5678);
        check("alu_commit", io_commit_valid, 1);
        check("alu_cpc", io_commit_pc, 32'h8000_0000);
        check("alu_busy", io_busy_valid, 1);
        check("alu_busy_rd", io_busy_rd, 5);
        check("alu_cnt_pre", io_inst_cnt, 0);
        idle();
        step();
        check("alu_cnt", io_inst_cnt, 1);
        check("alu_wen_off", io_wen, 0);
        check("alu_commit_off", io_commit_valid, 0);
        check("alu_ready", u_if.io_in_ready, 1);
        check("alu_busy_off", io_busy_valid, 0);

        // Loads back to back
        put(1, 32'h8000_0004, 5'd3, 1, 2'd1, 32'h0000_1001, 32'h8081_F2F3, 3'b000, 0);
        step();
        check("lb", io_wdata, 32'hFFFF_FFF2);
        check("lb_wen", io_wen, 1);
        put(1, 32'h8000_0008, 5'd3, 1, 2'd1, 32'h0000_1001, 32'h8081_F2F3, 3'b100, 0);
        step();
        check("lbu", io_wdata, 32'h0000_00F2);
        put(1, 32'h8000_000C, 5'd3, 1, 2'd1, 32'h0000_1002, 32'h8081_F2F3, 3'b001, 0);
        step();
        check("lh", io_wdata, 32'hFFFF_8081);
        put(1, 32'h8000_0010, 5'd3, 1, 2'd1, 32'h0000_1002, 32'h8081_F2F3, 3'b101, 0);
        step();
        check("lhu", io_wdata, 32'h0000_8081);
        put(1, 32'hFFFF_FFFC, 5'd1, 1, 2'd2, 32'h0, 32'h0, 3'd0, 0);
        step();
        check("pc4_wrap", io_wdata, 32'h0000_0000);
        check("pc4_wen", io_wen, 1);
        put(1, 32'h8000_0014, 5'd0, 1, 2'd0, 32'h0000_DEAD, 32'h0, 3'd0, 0);
        step();
        check("rd0_wen", io_wen, 0);
        check("rd0_commit", io_commit_valid, 1);
        check("rd0_busy", io_busy_valid, 0);
        put(1, 32'h8000_0018, 5'd9, 1, 2'd1, 32'h0000_1002, 32'h8081_F2F3, 3'b010, 0);
        step();
        check("lw_mis_wen", io_wen, 0);
        check("lw_mis_commit", io_commit_valid, 1);
        check("lw_mis_pre", io_misalign, 0);
        idle();
        step();
        check("mis_sticky", io_misalign, 1);
        check("cnt_8", io_inst_cnt, 8);

        // Four back-to-back, then hold while FULL
        for (int k = 0; k < 4; k++) begin
            put(1, 32'h8000_0100 + 32'(k * 4), 5'(10 + k), 1, 2'd0, 32'(100 + k), 32'h0, 3'd0, 0);
            step();
            check("b2b_waddr", io_waddr, 32'(10 + k));
            check("b2b_wen", io_wen, 1);
        end
        check("b2b_cnt", io_inst_cnt, 11);
        put(1, 32'h8000_0200, 5'd20, 1, 2'd0, 32'h0000_0BAD, 32'h0, 3'd0, 0);
        io_hold = 1'b1;
        #1;
        check("hold_ready", u_if.io_in_ready, 0);
        check("hold_wen", io_wen, 0);
        check("hold_commit", io_commit_valid, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold_waddr", io_waddr, 13);
            check("hold_wdata", io_wdata, 103);
            check("hold_cnt", io_inst_cnt, 11);
            check("hold_ready2", u_if.io_in_ready, 0);
            check("hold_mis", io_misalign, 1);
        end
        io_hold = 1'b0;
        idle();
        #1;
        check("release_wen", io_wen, 1);
        step();
        check("release_cnt", io_inst_cnt, 12);
        check("release_ready", u_if.io_in_ready, 1);

        // Hold while EMPTY still accepts
        io_hold = 1'b1;
        put(1, 32'h8000_0300, 5'd14, 1, 2'd0, 32'h0000_ABCD, 32'h0, 3'd0, 0);
        #1;
        check("hold_empty_ready", u_if.io_in_ready, 1);
        step();
        check("hold_empty_waddr", io_waddr, 14);
        check("hold_empty_busy", io_busy_valid, 1);
        check("hold_empty_wen", io_wen, 0);
        io_hold = 1'b0;
        idle();
        step();
        check("hold_empty_cnt", io_inst_cnt, 13);

        // ebreak then more traffic
        put(1, 32'h8000_0010, 5'd0, 0, 2'd0, 32'h0, 32'h0, 3'd0, 1);
        step();
        check("ebreak_commit", io_commit_valid, 1);
        check("ebreak_cpc", io_commit_pc, 32'h8000_0010);
        check("ebreak_halt_pre", io_halt, 0);
        put(1, 32'h8000_0014, 5'd15, 1, 2'd0, 32'h0000_0015, 32'h0, 3'd0, 0);
        step();
        check("halt", io_halt, 1);
        check("halt_ready", u_if.io_in_ready, 0);
        check("halt_commit", io_commit_valid, 0);
        check("halt_cnt", io_inst_cnt, 14);
        step();
        step();
        check("halt_stay", io_halt, 1);
        check("halt_stay_ready", u_if.io_in_ready, 0);
        check("halt_stay_cnt", io_inst_cnt, 14);
        check("halt_stay_wen", io_wen, 0);
        reset = 1'b1;
        #1;
        check("unhalt", io_halt, 0);
        check("unhalt_ready", u_if.io_in_ready, 1);
        check("unhalt_cnt", io_inst_cnt, 0);
        check("unhalt_mis", io_misalign, 0);
        idle();
        step();
        reset = 1'b0;

        // Reset in the middle of a pending write
        put(1, 32'h8000_0400, 5'd6, 1, 2'd0, 32'h0000_0055, 32'h0, 3'd0, 0);
        step();
        check("midrst_wen_pre", io_wen, 1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_wen", io_wen, 0);
        check("midrst_busy", io_busy_valid, 0);
        check("midrst_commit", io_commit_valid, 0);
        idle();
        step();
        reset = 1'b0;
        step();
        check("midrst_cnt", io_inst_cnt, 0);

`ifdef WB_BYPASS_EN
        put(1, 32'h8000_0500, 5'd7, 1, 2'd0, 32'h0000_0077, 32'h0, 3'd0, 0);
        step();
        io_hold = 1'b1;
        idle();
        io_byp_raddr1 = 5'd7;
        io_byp_raddr2 = 5'd8;
        #1;
        check("byp_hit1", io_byp_hit1, 1);
        check("byp_data1", io_byp_data1, 32'h0000_0077);
        check("byp_hit2", io_byp_hit2, 0);
        check("byp_data2", io_byp_data2, 0);
        io_hold = 1'b0;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
